// File: rtl/window_5x5_sequencer_pkg.sv
// Shared constants, types and helpers for the 5x5 window path.
package window_5x5_sequencer_pkg;

    localparam int unsigned PIX_W      = 8;
    localparam int unsigned KSIZE      = 5;
    localparam int unsigned CNT_W      = 11;
    localparam int unsigned COL_W      = PIX_W * KSIZE;
    localparam int unsigned WIN_W      = PIX_W * KSIZE * KSIZE;

    // Row lengths supported by the line-buffer variants.
    localparam int unsigned WIDTH_FULL = 420;
    localparam int unsigned WIDTH_HALF = 210;

    typedef logic [KSIZE-1:0]             asel_t;
    typedef logic [PIX_W-1:0]             pix_t;
    // Column vector, element 0 is the oldest row.
    typedef logic [KSIZE-1:0][PIX_W-1:0]  colvec_t;

    // Registered centre coordinates with their qualifier.
    typedef struct packed {
        logic             valid;
        logic [CNT_W-1:0] x;
        logic [CNT_W-1:0] y;
    } centre_t;

    localparam asel_t ASEL_INIT = asel_t'(1);

    // Rotate the row-select one-hot left by one, MSB wrapping to LSB.
    function automatic asel_t rot_left5(input asel_t a);
        return {a[KSIZE-2:0], a[KSIZE-1]};
    endfunction

    // Bit offset of byte (r, c) inside the flattened window.
    function automatic int unsigned win_idx(input int unsigned r, input int unsigned c);
        return PIX_W * (KSIZE * r + c);
    endfunction

endpackage

// File: rtl/window_5x5_sequencer_shift.sv
// 25-byte window register: shifts one column vector in from the right on enable.
module window_5x5_sequencer_shift
    import window_5x5_sequencer_pkg::*;
(
    input  logic             clock,
    input  logic             reset,
    input  logic             shift_en,
    input  colvec_t          col_in,
    output logic [WIN_W-1:0] window
);

    logic [KSIZE-1:0][KSIZE-1:0][PIX_W-1:0] win_q;

    for (genvar r = 0; r < KSIZE; r++) begin : g_row
        // Row r: column c takes column c+1, newest column enters at index KSIZE-1.
        always_ff @(posedge clock) begin
            if (reset) begin
                win_q[r] <= '0;
            end else if (shift_en) begin
                win_q[r] <= {col_in[r], win_q[r][KSIZE-1:1]};
            end
        end
    end

    assign window = win_q;

endmodule

// File: rtl/window_5x5_sequencer.sv
// Row rotation, column reordering and 5x5 window emission behind the line buffer.
module window_5x5_sequencer
    import window_5x5_sequencer_pkg::*;
#(
    parameter int unsigned WIDTH  = WIDTH_FULL,
    parameter int unsigned HEIGHT = 315
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              frame_start,
    input  logic [PIX_W-1:0]  din,
    input  logic              validin,
    input  logic [PIX_W-1:0]  row0,
    input  logic [PIX_W-1:0]  row1,
    input  logic [PIX_W-1:0]  row2,
    input  logic [PIX_W-1:0]  row3,
    input  logic [PIX_W-1:0]  row4,
    output logic [KSIZE-1:0]  asel,
    output logic [WIN_W-1:0]  window,
    output logic              win_valid,
    output logic [CNT_W-1:0]  x_out,
    output logic [CNT_W-1:0]  y_out,
    output logic              frame_done
);

    logic [CNT_W-1:0] col_q, row_q;
    asel_t            asel_q;
    centre_t          centre_q;
    logic             frame_done_q;

    // frame_start overrides the stored position so a coincident pixel lands at (0,0).
    logic [CNT_W-1:0] col_eff, row_eff;
    asel_t            asel_eff;
    logic [CNT_W-1:0] col_d, row_d;
    asel_t            asel_d;
    logic             last_col, last_row, interior;
    colvec_t          rows, col_vec;

    // Effective position and next counter / rotation state.
    always_comb begin
        col_eff  = frame_start ? '0 : col_q;
        row_eff  = frame_start ? '0 : row_q;
        asel_eff = frame_start ? ASEL_INIT : asel_q;
        last_col = (col_eff == CNT_W'(WIDTH - 1));
        last_row = (row_eff == CNT_W'(HEIGHT - 1));
        interior = (col_eff >= CNT_W'(KSIZE - 1)) && (row_eff >= CNT_W'(KSIZE - 1));
        col_d    = col_eff;
        row_d    = row_eff;
        asel_d   = asel_eff;
        if (validin) begin
            if (last_col) begin
                col_d = '0;
                if (last_row) begin
                    row_d  = '0;
                    asel_d = ASEL_INIT;
                end else begin
                    row_d  = row_eff + CNT_W'(1);
                    asel_d = rot_left5(asel_eff);
                end
            end else begin
                col_d = col_eff + CNT_W'(1);
            end
        end
    end

    // Reorder buffer outputs oldest-to-newest: the buffer after the selected one is oldest.
    always_comb begin
        rows             = {row4, row3, row2, row1, row0};
        col_vec          = '0;
        col_vec[KSIZE-1] = din;
        for (int k = 0; k < KSIZE - 1; k++) begin
            for (int j = 0; j < KSIZE; j++) begin
                if (asel_eff[3'(j)]) begin
                    col_vec[3'(k)] = rows[3'((j + k + 1) % KSIZE)];
                end
            end
        end
    end

    // Counters, rotation and registered centre / frame-done outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            col_q        <= '0;
            row_q        <= '0;
            asel_q       <= ASEL_INIT;
            centre_q     <= '0;
            frame_done_q <= 1'b0;
        end else begin
            col_q          <= col_d;
            row_q          <= row_d;
            asel_q         <= asel_d;
            frame_done_q   <= validin && last_col && last_row;
            centre_q.valid <= validin && interior;
            if (validin && interior) begin
                centre_q.x <= col_eff - CNT_W'(KSIZE / 2);
                centre_q.y <= row_eff - CNT_W'(KSIZE / 2);
            end
        end
    end

    window_5x5_sequencer_shift u_shift (
        .clock    (clock),
        .reset    (reset),
        .shift_en (validin),
        .col_in   (col_vec),
        .window   (window)
    );

    assign asel       = asel_q;
    assign win_valid  = centre_q.valid;
    assign x_out      = centre_q.x;
    assign y_out      = centre_q.y;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_window_5x5_sequencer.sv
// Scoreboard bench: frame image + line-buffer model predict every window.
module tb_window_5x5_sequencer;
    import window_5x5_sequencer_pkg::*;

    localparam int W = 210;
    localparam int H = 10;
    localparam int WIN_PER_FRAME = (W - 4) * (H - 4);

    logic         clock, reset, frame_start, validin;
    logic [7:0]   din, row0, row1, row2, row3, row4;
    logic [4:0]   asel;
    logic [199:0] window;
    logic         win_valid, frame_done;
    logic [10:0]  x_out, y_out;

    window_5x5_sequencer #(.WIDTH(W), .HEIGHT(H)) dut (
        .clock(clock), .reset(reset), .frame_start(frame_start), .din(din),
        .validin(validin), .row0(row0), .row1(row1), .row2(row2), .row3(row3),
        .row4(row4), .asel(asel), .window(window), .win_valid(win_valid),
        .x_out(x_out), .y_out(y_out), .frame_done(frame_done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct { logic wv; logic fd; logic [4:0] asel; } cyc_t;
    typedef struct { logic [199:0] w; logic [10:0] x; logic [10:0] y; } win_t;

    cyc_t cyc_q[$];
    win_t win_q[$];

    logic [7:0] img [H][W];
    logic [7:0] lb  [5][W];
    int m_col, m_row, m_s;
    int total = 0;
    int bad   = 0;
    int win_cnt = 0;
    int last_x = 0;
    int last_y = 0;

    task automatic chk(input string name, input logic [199:0] act, input logic [199:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%0h exp=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_col = 0;
        m_row = 0;
        m_s   = 0;
    endtask

    // Drive one cycle and predict what the DUT shows after the next rising edge.
    task automatic drive(input logic v, input logic fs, input logic [7:0] d);
        cyc_t ce;
        win_t we;
        @(negedge clock);
        if (fs) model_reset();
        validin     = v;
        frame_start = fs;
        din         = d;
        row0 = lb[0][m_col];
        row1 = lb[1][m_col];
        row2 = lb[2][m_col];
        row3 = lb[3][m_col];
        row4 = lb[4][m_col];
        ce.wv = 1'b0;
        ce.fd = 1'b0;
        if (v) begin
            img[m_row][m_col] = d;
            if (m_col >= 4 && m_row >= 4) begin
                ce.wv = 1'b1;
                we.w  = '0;
                for (int r = 0; r < 5; r++)
                    for (int c = 0; c < 5; c++)
                        we.w[win_idx(r, c) +: 8] = img[m_row - 4 + r][m_col - 4 + c];
                we.x = 11'(m_col - 2);
                we.y = 11'(m_row - 2);
                win_q.push_back(we);
            end
            lb[m_s][m_col] = d;
            if (m_col == W - 1) begin
                m_col = 0;
                if (m_row == H - 1) begin
                    ce.fd = 1'b1;
                    m_row = 0;
                    m_s   = 0;
                end else begin
                    m_row++;
                    m_s = (m_s + 1) % 5;
                end
            end else begin
                m_col++;
            end
        end
        ce.asel = 5'(1 << m_s);
        cyc_q.push_back(ce);
    endtask

    task automatic check_reset_state();
        chk("rst_asel", asel, 5'b00001);
        chk("rst_win_valid", win_valid, 1'b0);
        chk("rst_frame_done", frame_done, 1'b0);
        chk("rst_window", window, '0);
        chk("rst_x_out", x_out, '0);
        chk("rst_y_out", y_out, '0);
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset       = 1'b1;
        validin     = 1'b0;
        frame_start = 1'b0;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        model_reset();
        check_reset_state();
    endtask

    // mode 0: directed pattern, no gaps; 1: strict alternate gaps; 2: random gaps.
    // ab_kind 1 aborts with a standalone frame_start, 2 with a reset.
    task automatic run_frame(input int mode, input bit fs_first, input int ab_r,
                             input int ab_c, input int ab_kind);
        logic [7:0] d;
        bit first;
        first   = 1'b1;
        win_cnt = 0;
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                if (ab_kind != 0 && r == ab_r && c == ab_c) begin
                    if (ab_kind == 1) drive(1'b0, 1'b1, 8'h00);
                    else do_reset();
                    return;
                end
                if (mode == 1) drive(1'b0, 1'b0, 8'($urandom));
                else if (mode == 2)
                    while ($urandom_range(0, 2) == 0) drive(1'b0, 1'b0, 8'($urandom));
                d = (mode == 0) ? 8'((16 * r + c) & 255) : 8'($urandom);
                drive(1'b1, fs_first && first, d);
                first = 1'b0;
                if (mode == 0 && r == 4 && c == 4) begin
                    @(posedge clock);
                    #1;
                    chk("first_wv", win_valid, 1'b1);
                    chk("first_byte_r0c0", window[7:0], 8'h00);
                    chk("first_byte_r4c4", window[199:192], 8'h44);
                    chk("first_byte_r2c2", window[win_idx(2, 2) +: 8], 8'h22);
                    chk("first_x", x_out, 11'd2);
                    chk("first_y", y_out, 11'd2);
                end
            end
        end
    endtask

    task automatic end_of_frame_checks();
        drive(1'b0, 1'b0, 8'h00);
        @(posedge clock);
        #2;
        chk("frame_win_count", 32'(win_cnt), 32'(WIN_PER_FRAME));
        chk("frame_last_x", 32'(last_x), 32'(W - 3));
        chk("frame_last_y", 32'(last_y), 32'(H - 3));
    endtask

    // Monitor: compare each cycle's outputs against the queued predictions.
    always begin
        cyc_t ce;
        win_t we;
        @(posedge clock);
        #1;
        if (cyc_q.size() > 0) begin
            ce = cyc_q.pop_front();
            chk("win_valid", win_valid, ce.wv);
            chk("frame_done", frame_done, ce.fd);
            chk("asel", asel, ce.asel);
            if (win_valid) begin
                if (win_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_window act=x%0d,y%0d exp=none", x_out, y_out);
                end else begin
                    we = win_q.pop_front();
                    chk("window", window, we.w);
                    chk("x_out", x_out, we.x);
                    chk("y_out", y_out, we.y);
                    win_cnt++;
                    last_x = int'(x_out);
                    last_y = int'(y_out);
                end
            end
        end
    end

    initial begin
        reset = 1'b1; frame_start = 1'b0; validin = 1'b0; din = '0;
        row0 = '0; row1 = '0; row2 = '0; row3 = '0; row4 = '0;
        for (int k = 0; k < 5; k++) for (int c = 0; c < W; c++) lb[k][c] = '0;
        for (int r = 0; r < H; r++) for (int c = 0; c < W; c++) img[r][c] = '0;
        model_reset();
        repeat (3) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        check_reset_state();

        run_frame(0, 1'b0, 0, 0, 0);
        end_of_frame_checks();

        run_frame(1, 1'b1, 0, 0, 0);
        end_of_frame_checks();

        run_frame(2, 1'b0, 7, 100, 1);
        run_frame(2, 1'b0, 0, 0, 0);
        end_of_frame_checks();

        run_frame(2, 1'b0, 5, 50, 2);
        run_frame(2, 1'b0, 0, 0, 0);
        end_of_frame_checks();

        repeat (2) @(negedge clock);
        chk("cyc_queue_empty", 32'(cyc_q.size()), 32'd0);
        chk("win_queue_empty", 32'(win_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
